// File: rtl/button_press_classifier.sv
// Turns a debounced button level into short/long/auto-repeat pulses plus a held level.
// All outputs registered: each event appears the cycle after the deciding clock edge.
module button_press_classifier #(
  parameter int unsigned LONG_PRESS_CYCLES = 12_500_000,
  parameter int unsigned REPEAT_CYCLES     = 2_500_000,
  parameter int unsigned COUNT_WIDTH       = 24
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic in_i,
  output logic press_short_o,
  output logic press_long_o,
  output logic press_repeat_o,
  output logic held_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRESSED   = 2'b01,
    LONG_HELD = 2'b10
  } state_t;

  // count_q holds the number of high samples already accepted, so the
  // LONG_PRESS_CYCLES-th sample is the one seen while count_q is one short.
  localparam logic [COUNT_WIDTH-1:0] LONG_LAST   = COUNT_WIDTH'(LONG_PRESS_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] REPEAT_LAST = COUNT_WIDTH'(REPEAT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = '1;
  localparam bit                     REPEAT_EN   = (REPEAT_CYCLES != 0);

  state_t                   state_q;
  logic [COUNT_WIDTH-1:0]   count_q;
  logic                     armed_q;
  logic                     short_q;
  logic                     long_q;
  logic                     repeat_q;
  logic                     held_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      armed_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      if (!in_i) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          count_q <= '0;
          held_q  <= 1'b0;
          if (armed_q && in_i) begin
            state_q <= PRESSED;
            count_q <= COUNT_ONE;
            held_q  <= 1'b1;
          end
        end

        PRESSED: begin
          if (!in_i) begin
            state_q <= IDLE;
            short_q <= 1'b1;
            held_q  <= 1'b0;
            count_q <= '0;
          end else if (count_q == LONG_LAST) begin
            state_q <= LONG_HELD;
            long_q  <= 1'b1;
            held_q  <= 1'b1;
            count_q <= COUNT_ONE;
          end else begin
            held_q  <= 1'b1;
            count_q <= count_q + COUNT_ONE;
          end
        end

        LONG_HELD: begin
          if (!in_i) begin
            state_q <= IDLE;
            held_q  <= 1'b0;
            count_q <= '0;
          end else if (REPEAT_EN && (count_q == REPEAT_LAST)) begin
            repeat_q <= 1'b1;
            held_q   <= 1'b1;
            count_q  <= COUNT_ONE;
          end else begin
            held_q <= 1'b1;
            if (count_q != COUNT_MAX) begin
              count_q <= count_q + COUNT_ONE;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          count_q <= '0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign press_short_o  = short_q;
  assign press_long_o   = long_q;
  assign press_repeat_o = repeat_q;
  assign held_o         = held_q;

endmodule
